// File: rtl/uart_rx_clock_en.sv
// Bit-timing strobe generator for the UART receiver: counts clocks while count_en is high and
// emits a one-cycle en pulse every full or half bit period, as selected by half_full.
module uart_rx_clock_en #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic clk,
   input  logic reset,
   input  logic count_en,
   input  logic half_full,
   output logic en
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CNT_W-1:0] TERM_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] TERM_HALF = CNT_W'(HALF_BIT - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_baud
         $error("uart_rx_clock_en: CLK_FREQ / BAUD_RATE must be at least 2");
      end
   endgenerate

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             en_q, en_d;
   logic [CNT_W-1:0] term;

   // A >= compare lets a full-to-half switch past the half terminal fire at once instead of wrapping.
   always_comb begin
      term  = half_full ? TERM_HALF : TERM_FULL;
      cnt_d = '0;
      en_d  = 1'b0;
      if (count_en) begin
         if (cnt_q >= term) begin
            cnt_d = '0;
            en_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         en_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         en_q  <= en_d;
      end
   end

   assign en = en_q;

endmodule

// File: tb/tb_uart_rx_clock_en.sv
// Bench for uart_rx_clock_en at CLK_FREQ=100, BAUD_RATE=10 (10 clocks per bit, 5 per half bit):
// directed scenarios followed by randomized enable/mode/reset traffic against a period model.
module tb_uart_rx_clock_en;

   localparam int FULL_N = 10;
   localparam int HALF_N = 5;

   logic clk;
   logic reset;
   logic count_en;
   logic half_full;
   logic en;

   int checks;
   int failures;

   logic exp_q[$];
   int   elapsed;     // clocks spent in the current bit period
   logic model_en;    // strobe the model expects after the most recent edge

   uart_rx_clock_en #(
      .CLK_FREQ (100),
      .BAUD_RATE(10)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .count_en (count_en),
      .half_full(half_full),
      .en       (en)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a strobe comes once the period length in clocks has been used up.
   initial begin
      elapsed  = 0;
      model_en = 1'b0;
      forever begin
         @(posedge clk);
         if (!reset || !count_en) begin
            elapsed  = 0;
            model_en = 1'b0;
         end else if (elapsed + 1 >= (half_full ? HALF_N : FULL_N)) begin
            elapsed  = 0;
            model_en = 1'b1;
         end else begin
            elapsed  = elapsed + 1;
            model_en = 1'b0;
         end
         exp_q.push_back(model_en);
      end
   end

   // Monitor: compares the DUT against the queued expectation half a cycle after each edge.
   initial begin
      logic e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (en !== e) begin
               failures++;
               $display("FAIL en_strobe t=%0t got=%b exp=%b", $time, en, e);
            end
         end
      end
   end

   task automatic run_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_direct(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
      end
   endtask

   initial begin
      int guard;
      checks    = 0;
      failures  = 0;
      reset     = 1'b0;
      count_en  = 1'b1;
      half_full = 1'b0;

      // reset held low with count_en high: en stays low
      #1 check_direct("reset_low_en", en, 1'b0);
      run_cycles(3);
      check_direct("reset_hold_en", en, 1'b0);
      reset = 1'b1;

      // full period
      run_cycles(32);
      count_en = 1'b0;
      run_cycles(2);

      // half period
      half_full = 1'b1;
      count_en  = 1'b1;
      run_cycles(16);
      count_en = 1'b0;
      run_cycles(2);

      // disable mid-count, re-enable three cycles later
      half_full = 1'b0;
      count_en  = 1'b1;
      run_cycles(7);
      count_en = 1'b0;
      run_cycles(3);
      count_en = 1'b1;
      run_cycles(12);
      count_en = 1'b0;
      run_cycles(1);

      // mode switch full->half with the count already past the half terminal
      count_en = 1'b1;
      run_cycles(7);
      half_full = 1'b1;
      run_cycles(12);
      count_en  = 1'b0;
      half_full = 1'b0;
      run_cycles(1);

      // asynchronous reset while en is high
      count_en = 1'b1;
      guard    = 0;
      while (!model_en && guard < 3 * FULL_N) begin
         run_cycles(1);
         guard++;
      end
      check_direct("strobe_before_async_reset", model_en, 1'b1);
      #2 reset = 1'b0;
      #1 check_direct("async_reset_drop", en, 1'b0);
      run_cycles(2);
      reset = 1'b1;
      run_cycles(12);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 15) == 0) count_en = ~count_en;
         if ($urandom_range(0, 7) == 0) half_full = ~half_full;
         if ($urandom_range(0, 99) == 0) begin
            #($urandom_range(1, 4)) reset = 1'b0;
            #1 check_direct("rand_async_reset", en, 1'b0);
            run_cycles(1);
            reset = 1'b1;
         end
         if (i % 400 == 0) count_en = 1'b1;
         run_cycles(1);
      end

      count_en = 1'b0;
      run_cycles(2);
      #1 check_direct("queue_drained", exp_q.size() == 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
